decimal_align_shifter: RTL
==========================

Name: decimal_align_shifter

Overview:
- Operand-alignment stage directly downstream of the exponent subtractor in the decimal floating-point add/sub datapath.
- Takes the subtractor's outputs plus both BCD significands: Er (larger exponent), Greater (operand 1 has the larger or equal exponent), r = |E1-E2|.
- Swaps operands so the larger-exponent significand passes through unshifted, then right-shifts the other by r decimal digits, one digit per cycle.
- Produces the aligned pair with guard, round and sticky for the downstream BCD adder/rounder.

Parameters:
- DIGITS, 7, number of BCD digits per significand (width 4*DIGITS bits).
- EW, 8, exponent and shift-amount width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream operand set valid
- in_ready  output  1  block can accept an operand set
- M1  input  4*DIGITS  BCD significand of operand 1
- M2  input  4*DIGITS  BCD significand of operand 2
- Er  input  EW  larger exponent from the subtractor
- Greater  input  1  1: operand 1 has the larger or equal exponent
- r  input  EW  exponent difference, digits to shift
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts the result
- Ma  output  4*DIGITS  larger-exponent significand, unshifted
- Mb  output  4*DIGITS  smaller-exponent significand, aligned
- G  output  4  guard digit, first digit shifted out
- R  output  4  round digit, second digit shifted out
- S  output  1  sticky, OR of all digits shifted beyond R
- Eout  output  EW  registered Er
- Greater_out  output  1  registered Greater

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0. All data outputs (Ma, Mb, G, R, S, Eout, Greater_out) are 0.
- Reset mid-operation: the in-flight operand set is discarded. The cycle after rst, the block is in IDLE with reset values.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, accept (in_valid & in_ready):
  - Greater=1: Ma<=M1, Mb<=M2. Greater=0: Ma<=M2, Mb<=M1.
  - G, R, S <= 0. Eout<=Er, Greater_out<=Greater.
  - cnt <= min(r, DIGITS+2).
  - Next state SHIFT if cnt>0, else DONE.
- SHIFT, one step per cycle:
  - S <= S | (R!=0).
  - R <= G.
  - G <= Mb[3:0].
  - Mb <= Mb >> 4 (a zero digit enters at the MSD).
  - cnt decrements. The step with cnt==1 moves to DONE.
- Clamp: r > DIGITS+2 shifts exactly DIGITS+2 digits. This leaves Mb=0, G=R=0, and S=1 iff the original significand was nonzero.
- DONE: outputs are held stable while out_ready=0. On out_ready=1 the next state is IDLE. in_ready rises the following cycle; there is no same-cycle reaccept.
- Latency, accept to out_valid: min(r, DIGITS+2)+1 cycles (1 when r=0).
- Ma, Eout and Greater_out are constant from accept until the result is consumed.
- in_valid outside IDLE is ignored. Digits are not BCD-checked.

Optional Feature:
- Macro ALIGN_EARLY_EXIT_EN.
- Defined: whenever {Mb,G,R}==0, the block moves to DONE instead of continuing to shift. This applies at accept (with cnt>0) and during SHIFT. Output values are identical to the non-early-exit result; only latency shrinks.
- Undefined: latency is always min(r, DIGITS+2)+1.

Test Plan:
- r=0, Greater=1, M1=0x1234567, M2=0x7654321 -> out_valid 1 cycle after accept; Ma=0x1234567, Mb=0x7654321, G=0, R=0, S=0.
- r=3, Greater=0, M1=0x1234567, M2=0x9999999, Er=0x25 -> latency 4; Ma=0x9999999, Mb=0x0001234, G=5, R=6, S=1, Eout=0x25, Greater_out=0.
- r=200, Greater=1, M2=0x0000001 -> clamped to 9 shifts, latency 10; Mb=0, G=0, R=0, S=1.
- Backpressure: result of r=2, M2=0x1234567 (Mb=0x0012345, G=6, R=7) held with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle, in_ready=1 the cycle after.
- rst=1 on the 2nd SHIFT cycle of r=5 -> next cycle out_valid=0, in_ready=1, all data outputs 0; a new r=0 operand set is then processed normally.
- ALIGN_EARLY_EXIT_EN, M2=0, r=5, Greater=1 -> out_valid 1 cycle after accept, Mb=0, G=R=S=0. Without the macro, same values at latency 6.

Source files
------------

// File: rtl/decimal_align_shifter.sv
// rtl/decimal_align_shifter.sv - swaps BCD significands and right-shifts the smaller-exponent one by r digits
// Optional ALIGN_EARLY_EXIT_EN: finish as soon as {Mb,G,R} is all zero.
module decimal_align_shifter #(
    parameter int DIGITS = 7,
    parameter int EW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   M1,
    input  logic [4*DIGITS-1:0]   M2,
    input  logic [EW-1:0]         Er,
    input  logic                  Greater,
    input  logic [EW-1:0]         r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   Ma,
    output logic [4*DIGITS-1:0]   Mb,
    output logic [3:0]            G,
    output logic [3:0]            R,
    output logic                  S,
    output logic [EW-1:0]         Eout,
    output logic                  Greater_out
);
    localparam int            W     = 4 * DIGITS;
    localparam logic [EW-1:0] CLAMP = EW'(DIGITS + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  ma_q, ma_d;
    logic [W-1:0]  mb_q, mb_d;
    logic [3:0]    g_q, g_d;
    logic [3:0]    rd_q, rd_d;
    logic          s_q, s_d;
    logic [EW-1:0] eout_q, eout_d;
    logic          gt_q, gt_d;
    logic [EW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        g_d     = g_q;
        rd_d    = rd_q;
        s_d     = s_q;
        eout_d  = eout_q;
        gt_d    = gt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ma_d   = Greater ? M1 : M2;
                    mb_d   = Greater ? M2 : M1;
                    g_d    = 4'd0;
                    rd_d   = 4'd0;
                    s_d    = 1'b0;
                    eout_d = Er;
                    gt_d   = Greater;
                    // Beyond DIGITS+2 digits everything lands in sticky anyway.
                    cnt_d  = (r > CLAMP) ? CLAMP : r;
                    if (cnt_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
`ifdef ALIGN_EARLY_EXIT_EN
                        if (mb_d == '0) begin
                            state_d = DONE;
                        end
`endif
                    end
                end
            end
            SHIFT: begin
                s_d   = s_q | (rd_q != 4'd0);
                rd_d  = g_q;
                g_d   = mb_q[3:0];
                mb_d  = {4'd0, mb_q[W-1:4]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == EW'(1)) begin
                    state_d = DONE;
                end
`ifdef ALIGN_EARLY_EXIT_EN
                // Further steps would only OR zeros into sticky.
                if ({mb_d, g_d, rd_d} == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            g_q     <= '0;
            rd_q    <= '0;
            s_q     <= 1'b0;
            eout_q  <= '0;
            gt_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            g_q     <= g_d;
            rd_q    <= rd_d;
            s_q     <= s_d;
            eout_q  <= eout_d;
            gt_q    <= gt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign Ma          = ma_q;
    assign Mb          = mb_q;
    assign G           = g_q;
    assign R           = rd_q;
    assign S           = s_q;
    assign Eout        = eout_q;
    assign Greater_out = gt_q;

endmodule
